// File: rtl/alu_arbiter_if.sv
// Bundles the two request channels, the ALU operand/result bus and the
// response channel of alu_arbiter. slave = arbiter view, master = environment view.
interface alu_arbiter_if #(
    parameter int WIDTH  = 32,
    parameter int INST_W = 8
);
    logic              req0_valid;
    logic              req0_ready;
    logic [INST_W-1:0] req0_inst;
    logic [WIDTH-1:0]  req0_a;
    logic [WIDTH-1:0]  req0_b;

    logic              req1_valid;
    logic              req1_ready;
    logic [INST_W-1:0] req1_inst;
    logic [WIDTH-1:0]  req1_a;
    logic [WIDTH-1:0]  req1_b;

    logic [INST_W-1:0] alu_inst;
    logic [WIDTH-1:0]  alu_a;
    logic [WIDTH-1:0]  alu_b;
    logic [WIDTH-1:0]  alu_o;
    logic              alu_statupd8;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [WIDTH-1:0]  rsp_o;
    logic              rsp_stat;
    logic              rsp_err;
    logic              busy;

    modport slave (
        input  req0_valid, req0_inst, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_inst, req1_a, req1_b,
        output req1_ready,
        output alu_inst, alu_a, alu_b,
        input  alu_o, alu_statupd8,
        output rsp_valid, rsp_id, rsp_o, rsp_stat, rsp_err,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req0_valid, req0_inst, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_inst, req1_a, req1_b,
        input  req1_ready,
        input  alu_inst, alu_a, alu_b,
        output alu_o, alu_statupd8,
        input  rsp_valid, rsp_id, rsp_o, rsp_stat, rsp_err,
        output rsp_ready,
        input  busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters;
// one op in flight at a time: IDLE (accept) -> EXEC (drive ALU) -> RESP (return).
module alu_arbiter #(
    parameter int WIDTH    = 32,
    parameter int INST_W   = 8,
    parameter int MAX_INST = 4
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [INST_W-1:0] MAX_INST_L = INST_W'(MAX_INST);

    state_t            state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic              id_q, id_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;

    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]  rsp_o_q, rsp_o_d;
    logic              rsp_stat_q, rsp_stat_d;
    logic              rsp_err_q, rsp_err_d;

    logic              any_valid;
    logic              sel;

    // Contention goes to the port that was not granted last.
    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            sel = ~last_gnt_q;
        end else begin
            sel = bus.req1_valid;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        id_d        = id_q;
        inst_d      = inst_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_o_d     = rsp_o_q;
        rsp_stat_d  = rsp_stat_q;
        rsp_err_d   = rsp_err_q;

        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.alu_inst   = '0;
        bus.alu_a      = '0;
        bus.alu_b      = '0;

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    bus.req0_ready = ~sel;
                    bus.req1_ready = sel;
                    inst_d         = sel ? bus.req1_inst : bus.req0_inst;
                    a_d            = sel ? bus.req1_a    : bus.req0_a;
                    b_d            = sel ? bus.req1_b    : bus.req0_b;
                    last_gnt_d     = sel;
                    id_d           = sel;
                    state_d        = EXEC;
                end
            end
            EXEC: begin
                bus.alu_inst = inst_q;
                bus.alu_a    = a_q;
                bus.alu_b    = b_q;
                rsp_o_d      = bus.alu_o;
                rsp_stat_d   = bus.alu_statupd8;
                rsp_err_d    = (inst_q > MAX_INST_L);
                rsp_id_d     = id_q;
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_gnt_q  <= 1'b1;
            id_q        <= 1'b0;
            inst_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_o_q     <= '0;
            rsp_stat_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            id_q        <= id_d;
            inst_q      <= inst_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_o_q     <= rsp_o_d;
            rsp_stat_q  <= rsp_stat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        bus.rsp_valid = rsp_valid_q;
        bus.rsp_id    = rsp_id_q;
        bus.rsp_o     = rsp_o_q;
        bus.rsp_stat  = rsp_stat_q;
        bus.rsp_err   = rsp_err_q;
        bus.busy      = (state_q != IDLE);
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, contention and
// mid-op reset sequences, then randomized ops against a behavioural model.
module tb_alu_arbiter;

    localparam int WIDTH    = 32;
    localparam int INST_W   = 8;
    localparam int MAX_INST = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(WIDTH), .INST_W(INST_W)) bus ();

    alu_arbiter #(.WIDTH(WIDTH), .INST_W(INST_W), .MAX_INST(MAX_INST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit last_served;

    // Behavioural ALU: returns {status, result}.
    function automatic logic [32:0] alu_ref(input logic [7:0] inst, input logic [31:0] a, input logic [31:0] b);
        case (inst)
            8'd1:    return {(a == 32'd0), 32'd0};
            8'd2:    return {a[31], 32'd0};
            8'd3:    return {1'b0, a + b};
            8'd4:    return {1'b0, a - b};
            default: return 33'd0;
        endcase
    endfunction

    always_comb begin
        {bus.alu_statupd8, bus.alu_o} = alu_ref(bus.alu_inst, bus.alu_a, bus.alu_b);
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    function automatic bit ready_of(input bit p);
        return p ? bus.req1_ready : bus.req0_ready;
    endfunction

    task automatic set_req(input bit p, input bit v, input logic [7:0] inst, input logic [31:0] a, input logic [31:0] b);
        if (p) begin
            bus.req1_valid = v; bus.req1_inst = inst; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = v; bus.req0_inst = inst; bus.req0_a = a; bus.req0_b = b;
        end
    endtask

    // Ends at the negedge following the accepting edge (DUT in EXEC).
    task automatic start_op(input bit p, input logic [7:0] inst, input logic [31:0] a, input logic [31:0] b,
                            input bit already_valid);
        int i;
        if (!already_valid) begin
            @(negedge clk);
            set_req(p, 1'b1, inst, a, b);
        end
        #1;
        i = 0;
        while (!ready_of(p) && i < 10) begin
            @(negedge clk); #1; i++;
        end
        check("req_ready", 32'(ready_of(p)), 32'd1);
        check("other_ready", 32'(ready_of(!p)), 32'd0);
        @(posedge clk);
        last_served = p;
        @(negedge clk);
        set_req(p, 1'b0, 8'd0, 32'd0, 32'd0);
    endtask

    task automatic finish_op(input bit p, input logic [7:0] inst, input logic [31:0] a, input logic [31:0] b,
                             input int hold, input logic [31:0] eo, input bit es, input bit ee);
        #1;
        check("exec_alu_inst", 32'(bus.alu_inst), 32'(inst));
        check("exec_alu_a", bus.alu_a, a);
        check("exec_alu_b", bus.alu_b, b);
        check("exec_busy", 32'(bus.busy), 32'd1);
        check("exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk); #1;
        check("resp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("resp_alu_inst", 32'(bus.alu_inst), 32'd0);
        check("resp_alu_ab", bus.alu_a | bus.alu_b, 32'd0);
        for (int h = 0; h < hold; h++) begin
            set_req(!p, 1'b1, 8'd3, 32'd1, 32'd1);
            #1;
            check("hold_no_ready", 32'(bus.req0_ready | bus.req1_ready), 32'd0);
            check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_rsp_o", bus.rsp_o, eo);
            check("hold_rsp_id", 32'(bus.rsp_id), 32'(p));
            @(negedge clk);
        end
        if (hold > 0) set_req(!p, 1'b0, 8'd0, 32'd0, 32'd0);
        bus.rsp_ready = 1'b1;
        #1;
        check("rsp_o", bus.rsp_o, eo);
        check("rsp_stat", 32'(bus.rsp_stat), 32'(es));
        check("rsp_err", 32'(bus.rsp_err), 32'(ee));
        check("rsp_id", 32'(bus.rsp_id), 32'(p));
        check("rsp_no_ready", 32'(bus.req0_ready | bus.req1_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        #1;
        check("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("post_busy", 32'(bus.busy), 32'd0);
        check("post_rsp_o_kept", bus.rsp_o, eo);
        check("post_alu_inst", 32'(bus.alu_inst), 32'd0);
    endtask

    task automatic model_op(input bit p, input logic [7:0] inst, input logic [31:0] a, input logic [31:0] b,
                            input int hold);
        logic [32:0] r;
        r = alu_ref(inst, a, b);
        finish_op(p, inst, a, b, hold, r[31:0], r[32], (inst > 8'(MAX_INST)));
    endtask

    task automatic contend(input logic [7:0] i0, input logic [31:0] a0, input logic [31:0] b0,
                           input logic [7:0] i1, input logic [31:0] a1, input logic [31:0] b1);
        bit w;
        w = !last_served;
        @(negedge clk);
        set_req(1'b0, 1'b1, i0, a0, b0);
        set_req(1'b1, 1'b1, i1, a1, b1);
        if (w) begin
            start_op(1'b1, i1, a1, b1, 1'b1); model_op(1'b1, i1, a1, b1, 0);
            start_op(1'b0, i0, a0, b0, 1'b1); model_op(1'b0, i0, a0, b0, 0);
        end else begin
            start_op(1'b0, i0, a0, b0, 1'b1); model_op(1'b0, i0, a0, b0, 0);
            start_op(1'b1, i1, a1, b1, 1'b1); model_op(1'b1, i1, a1, b1, 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_served = 1'b1;
    endtask

    task automatic reset_mid(input bit in_resp);
        start_op(1'b0, 8'd3, 32'd1, 32'd2, 1'b0);
        if (in_resp) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_served = 1'b1;
        #1;
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_o", bus.rsp_o, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_alu_inst", 32'(bus.alu_inst), 32'd0);
        repeat (3) begin
            @(negedge clk); #1;
            check("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
    endtask

    typedef struct {
        bit          p;
        logic [7:0]  inst;
        logic [31:0] a;
        logic [31:0] b;
        int          hold;
        logic [31:0] eo;
        bit          es;
        bit          ee;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b0, 8'd3, 32'd5,          32'd7, 0, 32'd12,         1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'd2, 32'h8000_0000, 32'd0, 5, 32'd0,          1'b1, 1'b0};
        vecs[2] = '{1'b0, 8'd3, 32'hFFFF_FFFF, 32'd1, 0, 32'd0,          1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'd9, 32'd5,          32'd7, 0, 32'd0,          1'b0, 1'b1};
        vecs[4] = '{1'b1, 8'd4, 32'd10,         32'd3, 1, 32'd7,          1'b0, 1'b0};
        vecs[5] = '{1'b0, 8'd1, 32'd5,          32'd0, 0, 32'd0,          1'b0, 1'b0};
        vecs[6] = '{1'b1, 8'd0, 32'd123,        32'd4, 0, 32'd0,          1'b0, 1'b0};
        vecs[7] = '{1'b1, 8'd2, 32'h7FFF_FFFF, 32'd0, 0, 32'd0,          1'b0, 1'b0};
        vecs[8] = '{1'b0, 8'd4, 32'd0,          32'd1, 2, 32'hFFFF_FFFF, 1'b0, 1'b0};

        set_req(1'b0, 1'b0, 8'd0, 32'd0, 32'd0);
        set_req(1'b1, 1'b0, 8'd0, 32'd0, 32'd0);
        bus.rsp_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_o", bus.rsp_o, 32'd0);
        check("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
        check("reset_flags", 32'({bus.rsp_stat, bus.rsp_err}), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_alu_inst", 32'(bus.alu_inst), 32'd0);
        rst = 1'b0;
        last_served = 1'b1;

        for (int i = 0; i < 9; i++) begin
            start_op(vecs[i].p, vecs[i].inst, vecs[i].a, vecs[i].b, 1'b0);
            finish_op(vecs[i].p, vecs[i].inst, vecs[i].a, vecs[i].b, vecs[i].hold,
                      vecs[i].eo, vecs[i].es, vecs[i].ee);
        end

        // From reset, port 0 wins first contention; alternation over 4 ops.
        do_reset();
        contend(8'd4, 32'd3, 32'd5, 8'd1, 32'd0, 32'd0);
        contend(8'd3, 32'd9, 32'd9, 8'd2, 32'hF000_0000, 32'd0);

        reset_mid(1'b0);
        reset_mid(1'b1);
        contend(8'd3, 32'd1, 32'd1, 8'd4, 32'd1, 32'd2);

        for (int i = 0; i < 40; i++) begin
            bit          p;
            int unsigned r;
            logic [7:0]  inst;
            logic [31:0] a, b;
            r = $urandom_range(0, 7);
            inst = (r <= 5) ? 8'(r) : ((r == 6) ? 8'd9 : 8'd255);
            a = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom);
            b = 32'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                contend(inst, a, b, 8'($urandom_range(0, 5)), 32'($urandom), 32'($urandom));
            end else begin
                p = 1'($urandom_range(0, 1));
                start_op(p, inst, a, b, 1'b0);
                model_op(p, inst, a, b, int'($urandom_range(0, 3)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
